// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, commands and default timing for the HD44780 frame driver
package lcd_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    CFG,
    IDLE,
    ADDR1,
    LINE1,
    ADDR2,
    LINE2
  } lcd_state_t;

  // Per-item phase inside a sequencer state (one nibble or one byte plus its post-wait)
  typedef enum logic [2:0] {
    PH_HI,
    PH_HI_WAIT,
    PH_GAP,
    PH_LO,
    PH_LO_WAIT,
    PH_POST
  } lcd_phase_t;

  // Nibble transmitter states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_HOLD
  } tx_state_t;

  // Panel command bytes
  localparam logic [7:0] CMD_FUNC   = 8'h28;
  localparam logic [7:0] CMD_ENTRY  = 8'h06;
  localparam logic [7:0] CMD_DISPON = 8'h0C;
  localparam logic [7:0] CMD_CLR    = 8'h01;
  localparam logic [7:0] CMD_L1     = 8'h80;
  localparam logic [7:0] CMD_L2     = 8'hC0;

  // Default timing at 50 MHz, in clock cycles
  localparam int unsigned DEF_T_PWRUP = 750000;
  localparam int unsigned DEF_T_INIT1 = 205000;
  localparam int unsigned DEF_T_INIT2 = 5000;
  localparam int unsigned DEF_T_CMD   = 2000;
  localparam int unsigned DEF_T_CLR   = 82000;
  localparam int unsigned DEF_T_EPW   = 12;
  localparam int unsigned DEF_T_NGAP  = 50;

  // Only the two line states carry character data (RS=1)
  function automatic logic is_char_state(input lcd_state_t st);
    return (st == LINE1) || (st == LINE2);
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// rtl/lcd_nibble_tx.sv - one 4-bit LCD write: data setup, E strobe, hold, done pulse
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned T_EPW = DEF_T_EPW
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [3:0] i_nibble,
  input  logic       i_rs,
  output logic [3:0] o_d,
  output logic       o_e,
  output logic       o_rs,
  output logic       o_done
);

  tx_state_t  r_st;
  logic [7:0] r_cnt;
  logic [3:0] r_d;
  logic       r_e;
  logic       r_rs;
  logic       r_done;

  // Data/RS settle two cycles, E high T_EPW cycles, one low hold cycle, then bus returns to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= TX_IDLE;
      r_cnt  <= '0;
      r_d    <= '0;
      r_e    <= 1'b0;
      r_rs   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        TX_IDLE: begin
          if (i_start) begin
            r_d   <= i_nibble;
            r_rs  <= i_rs;
            r_cnt <= 8'd1;
            r_st  <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_e   <= 1'b1;
            r_cnt <= 8'(T_EPW - 1);
            r_st  <= TX_PULSE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        TX_PULSE: begin
          if (r_cnt == 8'd0) begin
            r_e  <= 1'b0;
            r_st <= TX_HOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        TX_HOLD: begin
          r_d    <= '0;
          r_rs   <= 1'b0;
          r_done <= 1'b1;
          r_st   <= TX_IDLE;
        end
        default: r_st <= TX_IDLE;
      endcase
    end
  end

  assign o_d    = r_d;
  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_done = r_done;

endmodule

// File: rtl/lcd_frame_driver.sv
// rtl/lcd_frame_driver.sv - 2x16 frame buffer, HD44780 init sequence and repaint streamer
module lcd_frame_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = DEF_T_PWRUP,
  parameter int unsigned T_INIT1 = DEF_T_INIT1,
  parameter int unsigned T_INIT2 = DEF_T_INIT2,
  parameter int unsigned T_CMD   = DEF_T_CMD,
  parameter int unsigned T_CLR   = DEF_T_CLR,
  parameter int unsigned T_EPW   = DEF_T_EPW,
  parameter int unsigned T_NGAP  = DEF_T_NGAP
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] dat,
  input  logic [4:0] addr,
  input  logic       we,
  input  logic       repaint,
  output logic       busy,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS
);

  logic [7:0]  r_buf [32];
  lcd_state_t  r_state;
  lcd_phase_t  r_phase;
  logic [3:0]  r_idx;
  logic [19:0] r_wait;
  logic        r_pending;
  logic        r_busy;
  logic        r_start;
  logic [3:0]  r_nib;
  logic        r_rs;
  logic [7:0]  r_byte;

  logic [7:0]  w_byte;
  logic [19:0] w_post;
  logic        w_rs;
  logic        w_done;

  // Frame buffer: write port is independent of the sequencer, reset fills it with spaces
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (we) begin
      r_buf[addr] <= dat;
    end
  end

  // Byte to send and its post-wait for the current state/index
  always_comb begin
    w_byte = 8'h00;
    w_post = 20'(T_CMD);
    case (r_state)
      INIT: begin
        w_byte = (r_idx == 4'd3) ? 8'h02 : 8'h03;
        if (r_idx == 4'd0)      w_post = 20'(T_INIT1);
        else if (r_idx == 4'd1) w_post = 20'(T_INIT2);
      end
      CFG: begin
        case (r_idx[1:0])
          2'd0:    w_byte = CMD_FUNC;
          2'd1:    w_byte = CMD_ENTRY;
          2'd2:    w_byte = CMD_DISPON;
          default: begin
            w_byte = CMD_CLR;
            w_post = 20'(T_CLR);
          end
        endcase
      end
      ADDR1:   w_byte = CMD_L1;
      LINE1:   w_byte = r_buf[{1'b0, r_idx}];
      ADDR2:   w_byte = CMD_L2;
      LINE2:   w_byte = r_buf[{1'b1, r_idx}];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_rs = is_char_state(r_state);

  // Sequencer: power-up wait, init nibbles, config bytes, then address + line streaming
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= PWRUP;
      r_phase   <= PH_HI;
      r_idx     <= '0;
      r_wait    <= 20'(T_PWRUP);
      r_pending <= 1'b0;
      r_busy    <= 1'b1;
      r_start   <= 1'b0;
      r_nib     <= '0;
      r_rs      <= 1'b0;
      r_byte    <= '0;
    end else begin
      r_start <= 1'b0;
      // Any repaint outside IDLE collapses into the single pending flag
      if (repaint && (r_state != IDLE)) r_pending <= 1'b1;
      case (r_state)
        PWRUP: begin
          if (r_wait == '0) begin
            r_state <= INIT;
            r_idx   <= '0;
            r_phase <= PH_HI;
          end else begin
            r_wait <= r_wait - 20'd1;
          end
        end
        IDLE: begin
          if (r_pending || repaint) begin
            r_state   <= ADDR1;
            r_phase   <= PH_HI;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          case (r_phase)
            PH_HI: begin
              r_byte  <= w_byte;
              r_rs    <= w_rs;
              r_nib   <= (r_state == INIT) ? w_byte[3:0] : w_byte[7:4];
              r_start <= 1'b1;
              r_phase <= PH_HI_WAIT;
            end
            PH_HI_WAIT: begin
              if (w_done) begin
                if (r_state == INIT) begin
                  r_wait  <= w_post;
                  r_phase <= PH_POST;
                end else begin
                  r_wait  <= 20'(T_NGAP);
                  r_phase <= PH_GAP;
                end
              end
            end
            PH_GAP: begin
              if (r_wait == '0) r_phase <= PH_LO;
              else              r_wait  <= r_wait - 20'd1;
            end
            PH_LO: begin
              r_nib   <= r_byte[3:0];
              r_start <= 1'b1;
              r_phase <= PH_LO_WAIT;
            end
            PH_LO_WAIT: begin
              if (w_done) begin
                r_wait  <= w_post;
                r_phase <= PH_POST;
              end
            end
            PH_POST: begin
              if (r_wait != '0) begin
                r_wait <= r_wait - 20'd1;
              end else begin
                r_phase <= PH_HI;
                case (r_state)
                  INIT: begin
                    if (r_idx == 4'd3) begin
                      r_state <= CFG;
                      r_idx   <= '0;
                    end else begin
                      r_idx <= r_idx + 4'd1;
                    end
                  end
                  CFG: begin
                    if (r_idx == 4'd3) begin
                      r_state <= IDLE;
                      r_idx   <= '0;
                      r_busy  <= r_pending || repaint;
                    end else begin
                      r_idx <= r_idx + 4'd1;
                    end
                  end
                  ADDR1: begin
                    r_state <= LINE1;
                    r_idx   <= '0;
                  end
                  LINE1: begin
                    if (r_idx == 4'd15) begin
                      r_state <= ADDR2;
                      r_idx   <= '0;
                    end else begin
                      r_idx <= r_idx + 4'd1;
                    end
                  end
                  ADDR2: begin
                    r_state <= LINE2;
                    r_idx   <= '0;
                  end
                  LINE2: begin
                    if (r_idx == 4'd15) begin
                      r_idx <= '0;
                      // A repaint landing on the final cycle still earns another pass
                      if (r_pending || repaint) begin
                        r_state   <= ADDR1;
                        r_pending <= 1'b0;
                      end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                      end
                    end else begin
                      r_idx <= r_idx + 4'd1;
                    end
                  end
                  default: r_state <= IDLE;
                endcase
              end
            end
            default: r_phase <= PH_HI;
          endcase
        end
      endcase
    end
  end

  assign busy = r_busy;

  lcd_nibble_tx #(
    .T_EPW (T_EPW)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (r_start),
    .i_nibble (r_nib),
    .i_rs     (r_rs),
    .o_d      (SF_D),
    .o_e      (LCD_E),
    .o_rs     (LCD_RS),
    .o_done   (w_done)
  );

endmodule
